// File: rtl/fetch_decode_buf_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_buf_if
// Handshake/bus bundle between fetch, the fetch-to-decode buffer and decode.
//   Fetch side  : instrF, incPCF, instrValidF, branchInstF, errF -> buffer
//                 readyF                                         <- buffer
//   Decode side : stallD, flush                                  -> buffer
//                 instrD, incPCD, validD, branchInstD, errD      <- buffer
//   Status      : count (occupancy, $clog2(DEPTH)+1 bits)        <- buffer
// Modports: master = fetch/decode environment, slave = the buffer.
// -----------------------------------------------------------------------------
interface fetch_decode_buf_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [15:0]      instrF;
    logic [15:0]      incPCF;
    logic             instrValidF;
    logic             branchInstF;
    logic             errF;
    logic             readyF;
    logic             stallD;
    logic             flush;
    logic [15:0]      instrD;
    logic [15:0]      incPCD;
    logic             validD;
    logic             branchInstD;
    logic             errD;
    logic [CNT_W-1:0] count;

    modport master (
        output instrF, incPCF, instrValidF, branchInstF, errF, stallD, flush,
        input  readyF, instrD, incPCD, validD, branchInstD, errD, count
    );

    modport slave (
        input  instrF, incPCF, instrValidF, branchInstF, errF, stallD, flush,
        output readyF, instrD, incPCD, validD, branchInstD, errD, count
    );
endinterface

// File: rtl/fetch_decode_buf.sv
// -----------------------------------------------------------------------------
// fetch_decode_buf
// Small FIFO between fetch and decode. Each entry carries instruction, PC+2,
// branch flag and fetch error; fields of one word always travel together.
// readyF comes from the registered occupancy only, so decode stalls never
// reach fetch combinationally. flush empties the buffer (wrong-path squash).
// When empty, decode sees NOP_INSTR with validD=0 and all other fields zero.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fetch_decode_buf_if.slave (fetch, decode and status signals)
//
// Parameters:
//   DEPTH     - number of entries (power of 2, >= 2)
//   NOP_INSTR - instruction presented when no valid word is at the head
//
// Build option:
//   FDBUF_BYPASS_EN - when defined, an incoming word offered to an empty
//   buffer (and no flush) is shown to decode in the same cycle; if decode
//   takes it, it is never written, otherwise it is stored as usual.
// -----------------------------------------------------------------------------
module fetch_decode_buf #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input logic              clk,
    input logic              rst,
    fetch_decode_buf_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        br;
        logic        err;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    entry_t in_word;
    entry_t head;
    entry_t out_word;
    logic   not_empty;
    logic   ready;
    logic   valid_out;
    logic   bypass;
    logic   push;
    logic   pop;
    logic   wr_en;
    logic   rd_adv;

    assign in_word = '{instr: bus.instrF, pc: bus.incPCF,
                       br: bus.branchInstF, err: bus.errF};

    always_comb begin
        head      = mem_q[rd_ptr_q];
        not_empty = (count_q != '0);
        ready     = (count_q != CNT_W'(DEPTH));

`ifdef FDBUF_BYPASS_EN
        bypass = ~not_empty & bus.instrValidF & ~bus.flush;
`else
        bypass = 1'b0;
`endif

        out_word  = '{instr: NOP_INSTR, pc: '0, br: 1'b0, err: 1'b0};
        valid_out = 1'b0;
        if (bypass) begin
            out_word  = in_word;
            valid_out = 1'b1;
        end else if (not_empty) begin
            out_word  = head;
            valid_out = 1'b1;
        end

        push = bus.instrValidF & ready & ~bus.flush;
        pop  = valid_out & ~bus.stallD & ~bus.flush;

        // A bypassed word consumed by decode is never stored; a stalled one is.
        wr_en  = push & ~(bypass & ~bus.stallD);
        rd_adv = pop & not_empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the write is held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    assign bus.readyF      = ready;
    assign bus.instrD      = out_word.instr;
    assign bus.incPCD      = out_word.pc;
    assign bus.branchInstD = out_word.br;
    assign bus.errD        = out_word.err;
    assign bus.validD      = valid_out;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_fetch_decode_buf.sv
module tb_fetch_decode_buf;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_decode_buf_if #(.DEPTH(DEPTH)) bus ();

    fetch_decode_buf #(.DEPTH(DEPTH), .NOP_INSTR(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: a plain queue of words
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        br;
        logic        err;
    } word_t;
    word_t q[$];

    task automatic drive(input logic flush, input logic valid, input logic stall,
                         input logic [15:0] instr, input logic [15:0] pc,
                         input logic br, input logic err);
        bus.flush       = flush;
        bus.instrValidF = valid;
        bus.stallD      = stall;
        bus.instrF      = instr;
        bus.incPCF      = pc;
        bus.branchInstF = br;
        bus.errF        = err;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // One cycle: drive, compare against model mid-cycle, clock, update model.
    task automatic step(input logic flush, input logic valid, input logic stall,
                        input logic [15:0] instr, input logic [15:0] pc,
                        input logic br, input logic err);
        word_t in, ex;
        logic  ev, bypass_ok, ready, pushok, popok;
        drive(flush, valid, stall, instr, pc, br, err);
        in = '{instr, pc, br, err};
`ifdef FDBUF_BYPASS_EN
        bypass_ok = 1'b1;
`else
        bypass_ok = 1'b0;
`endif
        @(negedge clk);
        if (q.size() > 0) begin
            ex = q[0]; ev = 1'b1;
        end else if (bypass_ok && valid && !flush) begin
            ex = in; ev = 1'b1;
        end else begin
            ex = '{16'h0800, 16'h0000, 1'b0, 1'b0}; ev = 1'b0;
        end
        ready = (q.size() < DEPTH);
        chk("m_instrD", bus.instrD, ex.instr);
        chk("m_incPCD", bus.incPCD, ex.pc);
        chk("m_validD", {15'b0, bus.validD}, {15'b0, ev});
        chk("m_branchD", {15'b0, bus.branchInstD}, {15'b0, ex.br});
        chk("m_errD", {15'b0, bus.errD}, {15'b0, ex.err});
        chk("m_count", {14'b0, bus.count}, 16'(q.size()));
        chk("m_readyF", {15'b0, bus.readyF}, {15'b0, ready});
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            pushok = valid && ready;
            popok  = ev && !stall;
            if (!(q.size() == 0 && popok)) begin
                if (popok)  void'(q.pop_front());
                if (pushok) q.push_back(in);
            end
        end
        #1;
    endtask

    typedef struct {
        logic        flush, valid, stall;
        logic [15:0] instr, pc;
        logic        br, err;
        logic [15:0] e_instr, e_pc;
        logic        e_valid, e_br, e_err;
        logic [1:0]  e_cnt;
        logic        e_ready;
    } vec_t;
    vec_t vecs[$];

    initial begin
        idle();
        // Reset state
        #12;
        chk("rst_count", {14'b0, bus.count}, 16'd0);
        chk("rst_validD", {15'b0, bus.validD}, 16'd0);
        chk("rst_instrD", bus.instrD, 16'h0800);
        chk("rst_incPCD", bus.incPCD, 16'h0000);
        chk("rst_readyF", {15'b0, bus.readyF}, 16'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Table: inputs for one edge, then outputs checked with fetch idle
        vecs.push_back('{0,1,1,16'hB001,16'h0102,0,0, 16'hB001,16'h0102,1,0,0,2'd1,1});
        vecs.push_back('{0,1,1,16'hB002,16'h0104,1,0, 16'hB001,16'h0102,1,0,0,2'd2,0});
        vecs.push_back('{0,1,1,16'hB003,16'h0106,0,0, 16'hB001,16'h0102,1,0,0,2'd2,0});
        vecs.push_back('{0,0,0,16'h0000,16'h0000,0,0, 16'hB002,16'h0104,1,1,0,2'd1,1});
        vecs.push_back('{0,0,0,16'h0000,16'h0000,0,0, 16'h0800,16'h0000,0,0,0,2'd0,1});
        vecs.push_back('{0,1,1,16'hD001,16'h0202,0,1, 16'hD001,16'h0202,1,0,1,2'd1,1});
        vecs.push_back('{0,1,0,16'hD002,16'h0204,0,0, 16'hD002,16'h0204,1,0,0,2'd1,1});
        vecs.push_back('{0,1,1,16'hD003,16'h0206,0,0, 16'hD002,16'h0204,1,0,0,2'd2,0});
        vecs.push_back('{1,1,0,16'hD004,16'h0208,0,0, 16'h0800,16'h0000,0,0,0,2'd0,1});
        vecs.push_back('{1,0,0,16'h0000,16'h0000,0,0, 16'h0800,16'h0000,0,0,0,2'd0,1});
        vecs.push_back('{0,1,1,16'hE001,16'h0302,1,1, 16'hE001,16'h0302,1,1,1,2'd1,1});
        vecs.push_back('{0,0,0,16'h0000,16'h0000,0,0, 16'h0800,16'h0000,0,0,0,2'd0,1});
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].stall, vecs[i].instr,
                  vecs[i].pc, vecs[i].br, vecs[i].err);
            @(posedge clk); #1;
            idle();
            #1;
            chk($sformatf("t%0d_instrD", i), bus.instrD, vecs[i].e_instr);
            chk($sformatf("t%0d_incPCD", i), bus.incPCD, vecs[i].e_pc);
            chk($sformatf("t%0d_validD", i), {15'b0, bus.validD}, {15'b0, vecs[i].e_valid});
            chk($sformatf("t%0d_branchD", i), {15'b0, bus.branchInstD}, {15'b0, vecs[i].e_br});
            chk($sformatf("t%0d_errD", i), {15'b0, bus.errD}, {15'b0, vecs[i].e_err});
            chk($sformatf("t%0d_count", i), {14'b0, bus.count}, {14'b0, vecs[i].e_cnt});
            chk($sformatf("t%0d_readyF", i), {15'b0, bus.readyF}, {15'b0, vecs[i].e_ready});
        end

        // Reset asserted mid-traffic takes effect without a clock edge
        step(0, 1, 1, 16'h9001, 16'h0002, 0, 0);
        step(0, 1, 1, 16'h9002, 16'h0004, 0, 0);
        idle();
        rst = 1'b0;
        #1;
        chk("mrst_count", {14'b0, bus.count}, 16'd0);
        chk("mrst_validD", {15'b0, bus.validD}, 16'd0);
        chk("mrst_instrD", bus.instrD, 16'h0800);
        chk("mrst_readyF", {15'b0, bus.readyF}, 16'd1);
        q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Streaming with decode never stalling
        step(0, 1, 0, 16'hA001, 16'h0002, 0, 0);
        chk("stream_cnt_le1", {15'b0, bus.count <= 1}, 16'd1);
        step(0, 1, 0, 16'hA002, 16'h0004, 0, 0);
        chk("stream_cnt_le1", {15'b0, bus.count <= 1}, 16'd1);
        step(0, 1, 0, 16'hA003, 16'h0006, 0, 0);
        chk("stream_cnt_le1", {15'b0, bus.count <= 1}, 16'd1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 0);

        // Push and pop together at count=1 across pointer wrap
        step(0, 1, 1, 16'hF000, 16'h1000, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, 16'hF000 + 16'(k), 16'h1000 + 16'(2*k), k[0], 0);
            chk("pp_count1", {14'b0, bus.count}, 16'd1);
        end
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 0);

`ifdef FDBUF_BYPASS_EN
        // Zero-latency path from an empty buffer
        drive(0, 1, 0, 16'hC00F, 16'h0042, 0, 0);
        #1;
        chk("byp_instrD", bus.instrD, 16'hC00F);
        chk("byp_validD", {15'b0, bus.validD}, 16'd1);
        @(posedge clk); #1;
        idle();
        #1;
        chk("byp_count0", {14'b0, bus.count}, 16'd0);
        drive(0, 1, 1, 16'hC010, 16'h0044, 0, 0);
        @(posedge clk); #1;
        idle();
        #1;
        chk("byp_stall_count1", {14'b0, bus.count}, 16'd1);
        chk("byp_stall_instrD", bus.instrD, 16'hC010);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 0);
`endif

        // Randomized traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 4), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
